johnson_decoder: RTL and testbench

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_pkg.sv | 14 +
 rtl/johnson_phase_decode.sv | 40 ++++
 rtl/johnson_decoder.sv | 146 ++++++++++++++
 tb/tb_johnson_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared constants and lock-state encoding for the Johnson code decoder.
// Imported by the phase decoder and the tracking top level.
package johnson_pkg;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_LOCK_COUNT = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_e;

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational Johnson code classifier: reports whether a sample is one of the
// 2*WIDTH legal codes and, if so, which phase it represents.
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]              code,
    output logic                          legal,
    output logic [$clog2(2*WIDTH)-1:0]    phase
);

    localparam int PW = $clog2(2*WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] inv;
    int               ones;

    always_comb begin
        inv  = ~code;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code[i]) ones++;
        end

        // Legal codes are a run of ones anchored at the MSB, or a run anchored at the LSB.
        if (code[WIDTH-1]) begin
            legal = ((inv & (inv + ONE)) == '0);
        end else begin
            legal = ((code & (code + ONE)) == '0);
        end

        if (code[WIDTH-1] || (code == '0)) begin
            phase = PW'(ones);
        end else begin
            phase = PW'(2*WIDTH - ones);
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter phase tracker: decodes each sample, classifies it against the
// previous phase, and runs an UNLOCKED/ACQUIRE/LOCKED lock state machine.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              code_in,
    input  logic                          code_valid,
    output logic [$clog2(2*WIDTH)-1:0]    phase,
    output logic                          phase_valid,
    output logic                          illegal_code,
    output logic                          seq_error,
    output logic                          stall,
    output logic                          locked,
    output logic [7:0]                    err_count
);

    localparam int PW  = $clog2(2*WIDTH);
    localparam int NPH = 2*WIDTH;
    localparam int CW  = $clog2(LOCK_COUNT+1);

    lock_state_e    state_q, state_d;
    logic [PW-1:0]  prev_q, prev_d;
    logic [CW-1:0]  step_q, step_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic           phase_valid_q, phase_valid_d;
    logic           illegal_q, illegal_d;
    logic           seq_err_q, seq_err_d;
    logic           stall_q, stall_d;
    logic           locked_q, locked_d;
    logic [7:0]     err_q, err_d;

    logic           dec_legal;
    logic [PW-1:0]  dec_phase;
    logic [PW-1:0]  exp_phase;
    logic [CW-1:0]  step_inc;
    logic           is_step;
    logic           is_rep;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    johnson_phase_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .code  (code_in),
        .legal (dec_legal),
        .phase (dec_phase)
    );

    // Explicit wrap keeps the increment modulo 2*WIDTH even when that is not a power of two.
    assign exp_phase = (prev_q == PW'(NPH-1)) ? '0 : prev_q + PW'(1);
    assign step_inc  = step_q + CW'(1);
    assign is_step   = (dec_phase == exp_phase);
    assign is_rep    = (dec_phase == prev_q);

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        step_d        = step_q;
        phase_d       = phase_q;
        err_d         = err_q;
        phase_valid_d = 1'b0;
        illegal_d     = 1'b0;
        seq_err_d     = 1'b0;
        stall_d       = 1'b0;

        if (code_valid) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
                err_d     = sat_inc(err_q);
                state_d   = ST_UNLOCKED;
            end else begin
                phase_valid_d = 1'b1;
                phase_d       = dec_phase;
                case (state_q)
                    ST_ACQUIRE, ST_LOCKED: begin
                        if (is_rep) begin
                            stall_d = 1'b1;
                        end else if (is_step) begin
                            prev_d = dec_phase;
                            if (state_q == ST_ACQUIRE) begin
                                step_d = step_inc;
                                if (step_inc >= CW'(LOCK_COUNT)) state_d = ST_LOCKED;
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            err_d     = sat_inc(err_q);
                            prev_d    = dec_phase;
                            step_d    = '0;
                            state_d   = ST_ACQUIRE;
                        end
                    end
                    default: begin
                        // First legal sample only establishes the reference phase.
                        prev_d  = dec_phase;
                        step_d  = '0;
                        state_d = ST_ACQUIRE;
                    end
                endcase
            end
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_UNLOCKED;
            prev_q        <= '0;
            step_q        <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            stall_q       <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            step_q        <= step_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            illegal_q     <= illegal_d;
            seq_err_q     <= seq_err_d;
            stall_q       <= stall_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign illegal_code = illegal_q;
    assign seq_error    = seq_err_q;
    assign stall        = stall_q;
    assign locked       = locked_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: directed scenarios plus random traffic, all checked
// against a table-driven reference of the Johnson sequence and lock rules.
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int NP = 2*W;
    localparam int LC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         code_valid;
    logic [W-1:0] code_in;
    logic [2:0]   phase;
    logic         phase_valid;
    logic         illegal_code;
    logic         seq_error;
    logic         stall;
    logic         locked;
    logic [7:0]   err_count;

    always #5 clk = ~clk;

    johnson_decoder #(
        .WIDTH      (W),
        .LOCK_COUNT (LC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .code_in      (code_in),
        .code_valid   (code_valid),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .illegal_code (illegal_code),
        .seq_error    (seq_error),
        .stall        (stall),
        .locked       (locked),
        .err_count    (err_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] jtab [NP];

    // Reference state: mode 0 = unlocked, 1 = acquiring, 2 = locked.
    int m_mode, m_prev, m_steps, m_err, m_phase;
    int m_pv, m_ill, m_seq, m_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int jindex(input logic [W-1:0] c);
        for (int i = 0; i < NP; i++) begin
            if (jtab[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [W-1:0] c);
        int idx;
        m_pv = 0; m_ill = 0; m_seq = 0; m_stall = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_steps = 0; m_err = 0; m_phase = 0;
        end else if (v) begin
            idx = jindex(c);
            if (idx < 0) begin
                m_ill  = 1;
                m_err  = (m_err < 255) ? m_err + 1 : 255;
                m_mode = 0;
            end else begin
                m_pv    = 1;
                m_phase = idx;
                if (m_mode == 0) begin
                    m_prev = idx; m_steps = 0; m_mode = 1;
                end else if (idx == m_prev) begin
                    m_stall = 1;
                end else if (idx == (m_prev + 1) % NP) begin
                    m_prev = idx;
                    if (m_mode == 1) begin
                        m_steps++;
                        if (m_steps >= LC) m_mode = 2;
                    end
                end else begin
                    m_seq   = 1;
                    m_err   = (m_err < 255) ? m_err + 1 : 255;
                    m_prev  = idx;
                    m_steps = 0;
                    m_mode  = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("phase",        32'(phase),        32'(m_phase));
        check("phase_valid",  32'(phase_valid),  32'(m_pv));
        check("illegal_code", 32'(illegal_code), 32'(m_ill));
        check("seq_error",    32'(seq_error),    32'(m_seq));
        check("stall",        32'(stall),        32'(m_stall));
        check("locked",       32'(locked),       32'(m_mode == 2));
        check("err_count",    32'(err_count),    32'(m_err));
    endtask

    task automatic cyc(input bit r, input bit v, input logic [W-1:0] c);
        @(negedge clk);
        reset      = r;
        code_valid = v;
        code_in    = c;
        @(posedge clk);
        model_step(r, v, c);
        #1;
        check_all();
    endtask

    initial begin
        int sp;
        int k;
        bit v;
        bit rs;
        logic [W-1:0] c;

        reset      = 1'b1;
        code_valid = 1'b0;
        code_in    = '0;
        jtab[0]    = '0;
        for (int i = 1; i < NP; i++) begin
            c       = jtab[i-1];
            jtab[i] = {~c[0], c[W-1:1]};
        end
        m_mode = 0; m_prev = 0; m_steps = 0; m_err = 0; m_phase = 0;

        cyc(1, 0, '0);
        cyc(1, 1, 4'b1010);
        check("rst_phase",  32'(phase),     0);
        check("rst_locked", 32'(locked),    0);
        check("rst_err",    32'(err_count), 0);

        // Full lap from reset: lock appears on the fifth sample.
        for (int i = 0; i < NP; i++) begin
            cyc(0, 1, jtab[i]);
            if (i == 3) check("lock_early", 32'(locked), 0);
            if (i == 4) check("lock_fifth", 32'(locked), 1);
        end
        check("lap_err", 32'(err_count), 0);

        cyc(0, 1, jtab[0]);
        check("wrap_seq",    32'(seq_error), 0);
        check("wrap_locked", 32'(locked),    1);
        check("wrap_phase",  32'(phase),     0);

        cyc(0, 1, jtab[1]);
        cyc(0, 1, jtab[2]);
        cyc(0, 1, 4'b1010);
        check("ill_pulse",  32'(illegal_code), 1);
        check("ill_phase",  32'(phase),        2);
        check("ill_locked", 32'(locked),       0);
        check("ill_err",    32'(err_count),    1);

        for (int i = 0; i < 12; i++) cyc(0, 1, jtab[i % NP]);
        check("relock_pre", 32'(locked), 1);
        check("at_phase3",  32'(phase),  3);
        cyc(0, 1, jtab[6]);
        check("jump_seq",    32'(seq_error), 1);
        check("jump_locked", 32'(locked),    0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, jtab[(7 + i) % NP]);
            if (i == 2) check("relock_early", 32'(locked), 0);
        end
        check("relocked", 32'(locked), 1);

        cyc(1, 0, '0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, jtab[0]);
            check("rep_stall", 32'(stall), (i == 0) ? 0 : 1);
        end
        check("rep_err",    32'(err_count), 0);
        check("rep_locked", 32'(locked),    0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, jtab[i]);
        check("rep_then_lock", 32'(locked), 1);

        cyc(1, 1, jtab[5]);
        check("rstlk_locked", 32'(locked),      0);
        check("rstlk_phase",  32'(phase),       0);
        check("rstlk_pv",     32'(phase_valid), 0);

        for (int i = 0; i < 300; i++) cyc(0, 1, 4'b0100);
        check("err_sat", 32'(err_count), 255);
        cyc(0, 0, 4'b0110);
        check("idle_err", 32'(err_count), 255);

        sp = 0;
        for (int n = 0; n < 2000; n++) begin
            k  = $urandom_range(0, 99);
            v  = ($urandom_range(0, 9) != 0);
            rs = (k < 2);
            if (k < 60)      sp = (sp + 1) % NP;
            else if (k < 88 && k >= 75) sp = $urandom_range(0, NP-1);
            c = jtab[sp];
            if (k >= 88) c = W'($urandom);
            cyc(rs, v, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
